fmul_issue: RTL and testbench

//  Issue/staging stage directly upstream of the combinational fmul datapath.

---
 rtl/fmul_issue.sv | 194 +++++++++++++++++++
 tb/tb_fmul_issue.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_issue.sv
// fmul_issue: issue/staging stage in front of a combinational fmul datapath.
//
// Operand pairs {x1, x2, tag} are queued in a small FIFO. The head entry is
// popped onto mul_x1/mul_x2 and held there for MC_CYCLES cycles, because the
// external multiplier is a multicycle path. After that the product and the
// overflow flag are captured and returned with the tag. Results leave in
// acceptance order. A sticky overflow flag records any overflowing capture.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_x1, in_x2, in_tag payload
//   mul_x1/mul_x2         registered operands to the multiplier
//   mul_y/mul_ovf         product and overflow from the multiplier
//   out_valid/out_ready   result handshake; out_y, out_tag, out_ovf payload
//   ovf_sticky/ovf_clr    sticky overflow flag and its clear
//   dbg_state/dbg_count   FSM state and FIFO occupancy, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A source holding valid keeps its payload stable until that edge. in_ready
// depends only on registered occupancy and rst, never on in_valid. out_valid
// stays high and out_y/out_tag/out_ovf stay stable until out_ready is seen.

module fmul_issue #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int MC_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_x1,
  input  logic [31:0]            in_x2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [31:0]            mul_x1,
  output logic [31:0]            mul_x2,
  input  logic [31:0]            mul_y,
  input  logic                   mul_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_y,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_ovf,
  output logic                   ovf_sticky,
  input  logic                   ovf_clr,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = $clog2(MC_CYCLES + 1);
  localparam int EW = 64 + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [MW-1:0]    cnt_q, cnt_d;
  logic [31:0]      mul_x1_q, mul_x1_d, mul_x2_q, mul_x2_d;
  logic [TAG_W-1:0] tag_r_q, tag_r_d, out_tag_q, out_tag_d;
  logic [31:0]      out_y_q, out_y_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             sticky_q, sticky_d;
  logic             push, pop, capture;
  logic [EW-1:0]    head;

  // No bypass: a full FIFO refuses even if a pop happens in the same cycle.
  assign in_ready = (count_q != CW'(DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  // FSM next state. pop loads the head onto the multiplier inputs; capture
  // samples the multiplier once the operands have been stable MC_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cnt_d   = MW'(MC_CYCLES);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - MW'(1);
        if (cnt_q == MW'(1)) begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            cnt_d   = MW'(MC_CYCLES);
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping and datapath registers.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    mul_x1_d  = mul_x1_q;
    mul_x2_d  = mul_x2_q;
    tag_r_d   = tag_r_q;
    out_y_d   = out_y_q;
    out_tag_d = out_tag_q;
    out_ovf_d = out_ovf_q;
    if (pop) begin
      mul_x1_d = head[EW-1 -: 32];
      mul_x2_d = head[EW-33 -: 32];
      tag_r_d  = head[TAG_W-1:0];
    end
    if (capture) begin
      out_y_d   = mul_y;
      out_ovf_d = mul_ovf;
      out_tag_d = tag_r_q;
    end
    // A new overflow capture takes priority over a clear in the same cycle.
    if (capture && mul_ovf) sticky_d = 1'b1;
    else if (ovf_clr)       sticky_d = 1'b0;
    else                    sticky_d = sticky_q;
  end

  // Storage array needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x1, in_x2, in_tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mul_x1_q    <= '0;
      mul_x2_q    <= '0;
      tag_r_q     <= '0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_x1_q    <= mul_x1_d;
      mul_x2_q    <= mul_x2_d;
      tag_r_q     <= tag_r_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
    end
  end

  assign mul_x1     = mul_x1_q;
  assign mul_x2     = mul_x2_q;
  assign out_valid  = out_valid_q;
  assign out_y      = out_y_q;
  assign out_tag    = out_tag_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;
  assign dbg_state  = state_q;
  assign dbg_count  = count_q;

endmodule

// File: tb/tb_fmul_issue.sv
// Testbench for fmul_issue. Provides a behavioural single-precision multiplier
// on the mul_* port, records accepted operations and returned results, and
// checks results, ordering, latency, throughput, backpressure, overflow
// stickiness and mid-operation reset.

module tb_fmul_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int MC    = 2;
  localparam int RW    = TAG_W + 33;  // {tag, ovf, y}

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      mul_x1;
  logic [31:0]      mul_x2;
  logic [31:0]      mul_y;
  logic             mul_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_ovf;
  logic             ovf_sticky;
  logic             ovf_clr;
  logic [1:0]       dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  int n_tests;
  int n_fail;
  int cyc;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int            got_cyc_q[$];

  fmul_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MC_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y), .mul_ovf(mul_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Reference multiplier: normal operands, truncated mantissa, zero on
  // underflow or zero/denormal input, signed infinity plus ovf on overflow.
  function automatic logic [32:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rand_fp(input int elo, input int ehi);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(1, 0));
    e = 8'($urandom_range(ehi, elo));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  always_comb {mul_ovf, mul_y} = fmul_ref(mul_x1, mul_x2);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // One clock: records handshakes that complete at this edge, then advances
  // to 1 time unit after the edge where outputs are sampled and inputs driven.
  task automatic tick();
    if (in_valid && in_ready) exp_q.push_back({in_tag, fmul_ref(in_x1, in_x2)});
    if (out_valid && out_ready) begin
      got_q.push_back({out_tag, out_ovf, out_y});
      got_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    bit ok;
    in_valid = 1'b1;
    in_x1    = a;
    in_x2    = b;
    in_tag   = t;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready never high for tag %0d, required acceptance", t);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL valid_timeout: out_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic drain(input int n);
    int i;
    out_ready = 1'b1;
    i = 0;
    while (got_q.size() < n && i < 100) begin
      tick();
      i++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results returned, required %0d", got_q.size(), n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 0 while rst=1", in_ready);
    end
    n_tests++;
    if ({out_valid, out_y, out_tag, out_ovf, ovf_sticky, mul_x1, mul_x2} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b y=%h tag=%0d ovf=%b sticky=%b x1=%h x2=%h, required all 0",
               out_valid, out_y, out_tag, out_ovf, ovf_sticky, mul_x1, mul_x2);
    end
    n_tests++;
    if (dbg_count !== '0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d state=%0d, required 0/0", dbg_count, dbg_state);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int            lat;
    logic [RW-1:0] g, e;
    out_ready = 1'b0;
    send(32'h40000000, 32'h40400000, 4'd5);
    wait_valid(lat);
    n_tests++;
    if (lat != MC + 1) begin
      n_fail++;
      $display("FAIL latency: out_valid after %0d cycles, required %0d", lat, MC + 1);
    end
    n_tests++;
    if (out_y !== 32'h40C00000 || out_tag !== 4'd5 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_result: y=%h tag=%0d ovf=%b, required 40c00000/5/0", out_y, out_tag, out_ovf);
    end
    n_tests++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_sticky: got %b, required 0", ovf_sticky);
    end
    drain(1);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc_q.pop_front());
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL latency_sb: got tag=%0d ovf=%b y=%h, required tag=%0d ovf=%b y=%h",
                 g[RW-1 -: TAG_W], g[32], g[31:0], e[RW-1 -: TAG_W], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_fill();
    int            nacc;
    bit            acc;
    logic [RW-1:0] g, e;
    out_ready = 1'b0;
    nacc      = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(nacc);
      in_x1    = rand_fp(64, 190);
      in_x2    = rand_fp(64, 190);
      acc      = in_ready;
      tick();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (nacc != DEPTH + 1) begin
      n_fail++;
      $display("FAIL fill_count: %0d accepted, required %0d", nacc, DEPTH + 1);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_ready: in_ready=%b when full, required 0", in_ready);
    end
    drain(DEPTH + 1);
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc_q.pop_front());
      n_tests++;
      if (g !== e || g[RW-1 -: TAG_W] !== TAG_W'(i)) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: got tag=%0d ovf=%b y=%h, required tag=%0d ovf=%b y=%h",
                 i, g[RW-1 -: TAG_W], g[32], g[31:0], i, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_ovf();
    int            lat;
    logic [RW-1:0] g, e;
    out_ready = 1'b0;
    send(32'h7F000000, 32'h7F000000, 4'd9);
    wait_valid(lat);
    n_tests++;
    if (out_y !== 32'h7F800000 || out_ovf !== 1'b1 || ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_result: y=%h ovf=%b sticky=%b, required 7f800000/1/1", out_y, out_ovf, ovf_sticky);
    end
    drain(1);
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hold: sticky=%b, required 1", ovf_sticky);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: sticky=%b, required 0", ovf_sticky);
    end
    // Accepted into an idle, empty block: capture lands MC+1 edges later.
    send(32'hFF000000, 32'h7F000000, 4'd10);
    for (int i = 0; i < MC; i++) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || ovf_sticky !== 1'b1 || out_y !== 32'hFF800000) begin
      n_fail++;
      $display("FAIL ovf_set_wins: valid=%b sticky=%b y=%h, required 1/1/ff800000", out_valid, ovf_sticky, out_y);
    end
    drain(2);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc_q.pop_front());
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL ovf_sb: got tag=%0d ovf=%b y=%h, required tag=%0d ovf=%b y=%h",
                 g[RW-1 -: TAG_W], g[32], g[31:0], e[RW-1 -: TAG_W], e[32], e[31:0]);
      end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_hold();
    int            lat, nacc;
    bit            acc;
    logic [31:0]   hold_x1;
    logic [RW-1:0] g, e, e0;
    out_ready = 1'b0;
    hold_x1   = rand_fp(64, 190);
    send(hold_x1, rand_fp(64, 190), 4'd3);
    wait_valid(lat);
    e0   = exp_q[0];
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(8 + i);
      in_x1    = rand_fp(64, 190);
      in_x2    = rand_fp(64, 190);
      acc      = in_ready;
      tick();
      if (acc) nacc++;
      n_tests++;
      if ({out_valid, out_tag, out_y, mul_x1} !== {1'b1, e0[RW-1 -: TAG_W], e0[31:0], hold_x1}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%b tag=%0d y=%h x1=%h, required 1/%0d/%h/%h",
                 i, out_valid, out_tag, out_y, mul_x1, e0[RW-1 -: TAG_W], e0[31:0], hold_x1);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (nacc != DEPTH || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_accept: accepted=%0d ready=%b, required %0d/0", nacc, in_ready, DEPTH);
    end
    drain(DEPTH + 1);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc_q.pop_front());
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL hold_sb: got tag=%0d ovf=%b y=%h, required tag=%0d ovf=%b y=%h",
                 g[RW-1 -: TAG_W], g[32], g[31:0], e[RW-1 -: TAG_W], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int            lat, nacc;
    bit            acc;
    logic [RW-1:0] g, e;
    out_ready = 1'b0;
    nacc      = 0;
    for (int i = 0; i < 20 && nacc < DEPTH + 1; i++) begin
      in_valid = 1'b1;
      in_tag   = TAG_W'(nacc);
      in_x1    = rand_fp(64, 190);
      in_x2    = rand_fp(64, 190);
      acc      = in_ready;
      tick();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    wait_valid(lat);
    // Return one result so the next operation starts executing with 3 queued.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || dbg_count !== '0 || in_ready !== 1'b1 || mul_x1 !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: valid=%b count=%0d ready=%b x1=%h, required 0/0/1/0",
               out_valid, dbg_count, in_ready, mul_x1);
    end
    n_tests++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_first: %0d results before reset, required 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc_q.pop_front());
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rstmid_sb: got tag=%0d ovf=%b y=%h, required tag=%0d ovf=%b y=%h",
                 g[RW-1 -: TAG_W], g[32], g[31:0], e[RW-1 -: TAG_W], e[32], e[31:0]);
      end
    end
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    out_ready = 1'b0;
    n_tests++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_stale: %0d results after reset, valid=%b, required 0/0", got_q.size(), out_valid);
    end
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_back_to_back();
    int            sent;
    bit            acc;
    logic [RW-1:0] g, e;
    got_cyc_q.delete();
    out_ready = 1'b1;
    sent      = 0;
    for (int i = 0; i < 200 && (sent < 8 || got_q.size() < 8); i++) begin
      if (sent < 8) begin
        in_valid = 1'b1;
        in_tag   = TAG_W'(sent);
        in_x1    = rand_fp(1, 254);
        in_x2    = rand_fp(1, 254);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: %0d results, required 8", got_q.size());
    end
    for (int i = 1; i < got_cyc_q.size(); i++) begin
      n_tests++;
      if (got_cyc_q[i] - got_cyc_q[i-1] != MC + 1) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: %0d cycles between results, required %0d",
                 i, got_cyc_q[i] - got_cyc_q[i-1], MC + 1);
      end
    end
    for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      void'(got_cyc_q.pop_front());
      n_tests++;
      if (g !== e || g[RW-1 -: TAG_W] !== TAG_W'(i)) begin
        n_fail++;
        $display("FAIL b2b_sb[%0d]: got tag=%0d ovf=%b y=%h, required tag=%0d ovf=%b y=%h",
                 i, g[RW-1 -: TAG_W], g[32], g[31:0], i, e[32], e[31:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x1     = '0;
    in_x2     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_ovf();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
